// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: MEM-stage FSM states and MEM/WB field widths.
package pipe_pkg;

  localparam int DATA_W       = 32;
  localparam int PC_W         = 32;
  localparam int REG_ADDR_W_D = 5;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_t;

  // Word accesses must have the two byte-offset bits clear.
  function automatic logic misaligned(input logic [DATA_W-1:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// EX/MEM -> MEM stage bus plus the MEM/WB and branch-resolution outputs.
interface mem_access_stage_if #(
  parameter int REG_ADDR_W = 5
) ();
  import pipe_pkg::*;

  logic                  Valid_In;
  logic                  RegWriteEN_In;
  logic                  Mem2RegSEL_In;
  logic                  MemWriteEN_In;
  logic                  Branch_In;
  logic                  ZeroFlag_In;
  logic [DATA_W-1:0]     ALUResult_In;
  logic [DATA_W-1:0]     WriteData_In;
  logic [REG_ADDR_W-1:0] WriteReg_In;
  logic [PC_W-1:0]       PC_In;

  logic                  PCSrc_Out;
  logic [PC_W-1:0]       BranchTarget_Out;
  logic                  Stall_Out;
  logic                  Valid_Out;
  logic                  RegWriteEN_Out;
  logic                  Mem2RegSEL_Out;
  logic [DATA_W-1:0]     ReadData_Out;
  logic [DATA_W-1:0]     ALUResult_Out;
  logic [REG_ADDR_W-1:0] WriteReg_Out;
  logic                  Fault_Out;

  modport slave (
    input  Valid_In, RegWriteEN_In, Mem2RegSEL_In, MemWriteEN_In, Branch_In,
           ZeroFlag_In, ALUResult_In, WriteData_In, WriteReg_In, PC_In,
    output PCSrc_Out, BranchTarget_Out, Stall_Out, Valid_Out, RegWriteEN_Out,
           Mem2RegSEL_Out, ReadData_Out, ALUResult_Out, WriteReg_Out, Fault_Out
  );

  modport master (
    output Valid_In, RegWriteEN_In, Mem2RegSEL_In, MemWriteEN_In, Branch_In,
           ZeroFlag_In, ALUResult_In, WriteData_In, WriteReg_In, PC_In,
    input  PCSrc_Out, BranchTarget_Out, Stall_Out, Valid_Out, RegWriteEN_Out,
           Mem2RegSEL_Out, ReadData_Out, ALUResult_Out, WriteReg_Out, Fault_Out
  );

endinterface

// File: rtl/dmem_ram.sv
// Word-addressed data RAM: synchronous write, asynchronous read, no reset of contents.
module dmem_ram
  import pipe_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int IDX_W = 8
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_idx,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Single write port.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_idx] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: data RAM access, branch resolution, MEM/WB register, load-latency stall.
// Optional misaligned-access trap enabled by defining MEM_MISALIGN_TRAP_EN.
module mem_access_stage
  import pipe_pkg::*;
#(
  parameter int DMEM_DEPTH  = 256,
  parameter int MEM_LATENCY = 1,
  parameter int REG_ADDR_W  = 5
) (
  input logic CLOCK,
  input logic RESET,
  mem_access_stage_if.slave bus
);

  localparam int IDX_W = $clog2(DMEM_DEPTH);
  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);

  mem_state_t            r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_valid;
  logic                  r_regwrite;
  logic                  r_mem2reg;
  logic [DATA_W-1:0]     r_rdata;
  logic [DATA_W-1:0]     r_alu;
  logic [REG_ADDR_W-1:0] r_wreg;
  logic                  r_fault;

  logic [IDX_W-1:0]  w_idx;
  logic [DATA_W-1:0] w_rdata;
  logic              w_misalign;
  logic              w_store;
  logic              w_load;
  logic              w_stall;

  assign w_idx = bus.ALUResult_In[2 +: IDX_W];

`ifdef MEM_MISALIGN_TRAP_EN
  assign w_misalign = bus.Valid_In & (bus.MemWriteEN_In | bus.Mem2RegSEL_In)
                    & misaligned(bus.ALUResult_In);
`else
  assign w_misalign = 1'b0;
`endif

  // A store flag overrides a load flag on the same instruction.
  assign w_store = bus.Valid_In & bus.MemWriteEN_In & ~w_misalign;
  assign w_load  = bus.Valid_In & bus.Mem2RegSEL_In & ~bus.MemWriteEN_In & ~w_misalign;

  // Stall covers the acceptance cycle and every busy cycle before the last one.
  always_comb begin
    w_stall = 1'b0;
    if (RESET) begin
      w_stall = 1'b0;
    end else if (MEM_LATENCY > 1) begin
      case (r_state)
        IDLE:    w_stall = w_load;
        BUSY:    w_stall = w_load & (r_cnt != CNT_LAST);
        default: w_stall = 1'b0;
      endcase
    end else begin
      w_stall = 1'b0;
    end
  end

  dmem_ram #(
    .DEPTH (DMEM_DEPTH),
    .IDX_W (IDX_W)
  ) u_dmem_ram (
    .i_clk   (CLOCK),
    .i_we    (w_store & ~RESET),
    .i_idx   (w_idx),
    .i_wdata (bus.WriteData_In),
    .o_rdata (w_rdata)
  );

  // Load FSM, latency counter and MEM/WB register.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_state    <= IDLE;
      r_cnt      <= {CNT_W{1'b0}};
      r_valid    <= 1'b0;
      r_regwrite <= 1'b0;
      r_mem2reg  <= 1'b0;
      r_rdata    <= {DATA_W{1'b0}};
      r_alu      <= {DATA_W{1'b0}};
      r_wreg     <= {REG_ADDR_W{1'b0}};
      r_fault    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_load && (MEM_LATENCY > 1)) begin
            r_state <= BUSY;
            r_cnt   <= CNT_ONE;
          end else begin
            r_state <= IDLE;
            r_cnt   <= {CNT_W{1'b0}};
          end
        end
        BUSY: begin
          // Leaving early on a vanished load keeps the FSM from locking up.
          if (!w_load || (r_cnt == CNT_LAST)) begin
            r_state <= IDLE;
            r_cnt   <= {CNT_W{1'b0}};
          end else begin
            r_cnt   <= r_cnt + CNT_ONE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= {CNT_W{1'b0}};
        end
      endcase

      if (w_stall) begin
        r_valid    <= 1'b0;
        r_regwrite <= 1'b0;
        r_mem2reg  <= 1'b0;
        r_rdata    <= {DATA_W{1'b0}};
        r_alu      <= {DATA_W{1'b0}};
        r_wreg     <= {REG_ADDR_W{1'b0}};
        r_fault    <= 1'b0;
      end else begin
        r_valid    <= bus.Valid_In;
        r_regwrite <= bus.Valid_In & bus.RegWriteEN_In & ~w_misalign;
        r_mem2reg  <= w_load;
        r_rdata    <= w_load ? w_rdata : {DATA_W{1'b0}};
        r_alu      <= bus.ALUResult_In;
        r_wreg     <= bus.WriteReg_In;
        r_fault    <= w_misalign;
      end
    end
  end

  assign bus.PCSrc_Out        = bus.Valid_In & bus.Branch_In & bus.ZeroFlag_In & ~w_stall;
  assign bus.BranchTarget_Out = bus.PC_In;
  assign bus.Stall_Out        = w_stall;
  assign bus.Valid_Out        = r_valid;
  assign bus.RegWriteEN_Out   = r_regwrite;
  assign bus.Mem2RegSEL_Out   = r_mem2reg;
  assign bus.ReadData_Out     = r_rdata;
  assign bus.ALUResult_Out    = r_alu;
  assign bus.WriteReg_Out     = r_wreg;
  assign bus.Fault_Out        = r_fault;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage at load latencies 1, 3 and 4.
module tb_mem_access_stage;

  logic        clk;
  logic        rst;
  logic        s_valid, s_regwrite, s_mem2reg, s_memwrite, s_branch, s_zero;
  logic [31:0] s_alu, s_wdata, s_pc;
  logic [4:0]  s_wreg;
  logic        en1, en3, en4;
  int          vectors;
  int          miscompares;

  mem_access_stage_if #(.REG_ADDR_W(5)) if1 ();
  mem_access_stage_if #(.REG_ADDR_W(5)) if3 ();
  mem_access_stage_if #(.REG_ADDR_W(5)) if4 ();

  assign if1.Valid_In      = s_valid & en1;
  assign if1.RegWriteEN_In = s_regwrite;
  assign if1.Mem2RegSEL_In = s_mem2reg;
  assign if1.MemWriteEN_In = s_memwrite;
  assign if1.Branch_In     = s_branch;
  assign if1.ZeroFlag_In   = s_zero;
  assign if1.ALUResult_In  = s_alu;
  assign if1.WriteData_In  = s_wdata;
  assign if1.WriteReg_In   = s_wreg;
  assign if1.PC_In         = s_pc;

  assign if3.Valid_In      = s_valid & en3;
  assign if3.RegWriteEN_In = s_regwrite;
  assign if3.Mem2RegSEL_In = s_mem2reg;
  assign if3.MemWriteEN_In = s_memwrite;
  assign if3.Branch_In     = s_branch;
  assign if3.ZeroFlag_In   = s_zero;
  assign if3.ALUResult_In  = s_alu;
  assign if3.WriteData_In  = s_wdata;
  assign if3.WriteReg_In   = s_wreg;
  assign if3.PC_In         = s_pc;

  assign if4.Valid_In      = s_valid & en4;
  assign if4.RegWriteEN_In = s_regwrite;
  assign if4.Mem2RegSEL_In = s_mem2reg;
  assign if4.MemWriteEN_In = s_memwrite;
  assign if4.Branch_In     = s_branch;
  assign if4.ZeroFlag_In   = s_zero;
  assign if4.ALUResult_In  = s_alu;
  assign if4.WriteData_In  = s_wdata;
  assign if4.WriteReg_In   = s_wreg;
  assign if4.PC_In         = s_pc;

  mem_access_stage #(.DMEM_DEPTH(256), .MEM_LATENCY(1), .REG_ADDR_W(5)) u_lat1 (
    .CLOCK (clk), .RESET (rst), .bus (if1.slave));
  mem_access_stage #(.DMEM_DEPTH(256), .MEM_LATENCY(3), .REG_ADDR_W(5)) u_lat3 (
    .CLOCK (clk), .RESET (rst), .bus (if3.slave));
  mem_access_stage #(.DMEM_DEPTH(256), .MEM_LATENCY(4), .REG_ADDR_W(5)) u_lat4 (
    .CLOCK (clk), .RESET (rst), .bus (if4.slave));

  always #5 clk = ~clk;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    s_valid = 1'b0; s_regwrite = 1'b0; s_mem2reg = 1'b0; s_memwrite = 1'b0;
    s_branch = 1'b0; s_zero = 1'b0;
    s_alu = 32'h0; s_wdata = 32'h0; s_pc = 32'h0; s_wreg = 5'd0;
  endtask

  task automatic drive(input logic v, input logic rw, input logic m2r, input logic mw,
                       input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] wr);
    set_idle();
    s_valid = v; s_regwrite = rw; s_mem2reg = m2r; s_memwrite = mw;
    s_alu = alu; s_wdata = wd; s_wreg = wr;
  endtask

  task automatic sel(input int which);
    en1 = (which == 1);
    en3 = (which == 3);
    en4 = (which == 4);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    clk = 1'b0;
    rst = 1'b1;
    set_idle();
    sel(1);
    tick();
    tick();

    // Reset state
    check1 ("rst_valid",    if1.Valid_Out, 1'b0);
    check1 ("rst_regwrite", if1.RegWriteEN_Out, 1'b0);
    check32("rst_rdata",    if1.ReadData_Out, 32'h0);
    check1 ("rst_fault",    if1.Fault_Out, 1'b0);
    check1 ("rst_stall4",   if4.Stall_Out, 1'b0);
    rst = 1'b0;

    // Store then load, latency 1
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 5'd0);
    #1 check1("st_stall", if1.Stall_Out, 1'b0);
    tick();
    check1("st_valid", if1.Valid_Out, 1'b1);
    check1("st_rw",    if1.RegWriteEN_Out, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 5'd5);
    #1 check1("ld1_stall", if1.Stall_Out, 1'b0);
    tick();
    check32("ld1_data",  if1.ReadData_Out, 32'hDEADBEEF);
    check1 ("ld1_valid", if1.Valid_Out, 1'b1);
    check1 ("ld1_m2r",   if1.Mem2RegSEL_Out, 1'b1);
    check32("ld1_wreg",  {27'd0, if1.WriteReg_Out}, 32'd5);

    // Address wrap: 0x400 maps to word 0
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h12345678, 5'd0);
    tick();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h400, 32'h0, 5'd6);
    tick();
    check32("wrap_data", if1.ReadData_Out, 32'h12345678);

    // Non-memory op
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'hABCD, 32'h0, 5'd3);
    tick();
    check32("alu_rdata", if1.ReadData_Out, 32'h0);
    check32("alu_pass",  if1.ALUResult_Out, 32'hABCD);
    check1 ("alu_rw",    if1.RegWriteEN_Out, 1'b1);

    // Invalid store is a bubble and must not write
    drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h10, 32'h11111111, 5'd4);
    tick();
    check1("bub_valid", if1.Valid_Out, 1'b0);
    check1("bub_rw",    if1.RegWriteEN_Out, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 5'd5);
    tick();
    check32("bub_nowr", if1.ReadData_Out, 32'hDEADBEEF);

    // Store and load flags together: store wins, no read
    drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h14, 32'h99, 5'd0);
    tick();
    check32("both_rdata", if1.ReadData_Out, 32'h0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h14, 32'h0, 5'd1);
    tick();
    check32("both_wr", if1.ReadData_Out, 32'h99);

    // Branch resolution
    set_idle();
    s_valid = 1'b1; s_branch = 1'b1; s_zero = 1'b1; s_pc = 32'h40;
    #1 check1("br_taken",  if1.PCSrc_Out, 1'b1);
    check32("br_target",   if1.BranchTarget_Out, 32'h40);
    s_zero = 1'b0;
    #1 check1("br_nozero", if1.PCSrc_Out, 1'b0);
    s_zero = 1'b1; s_valid = 1'b0;
    #1 check1("br_invalid", if1.PCSrc_Out, 1'b0);
    set_idle();
    tick();

    // Misaligned store @0x13
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h13, 32'h77777777, 5'd8);
    tick();
`ifdef MEM_MISALIGN_TRAP_EN
    check1("mis_fault", if1.Fault_Out, 1'b1);
    check1("mis_rw",    if1.RegWriteEN_Out, 1'b0);
    check1("mis_valid", if1.Valid_Out, 1'b1);
`else
    check1("mis_fault", if1.Fault_Out, 1'b0);
`endif
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 5'd2);
    tick();
`ifdef MEM_MISALIGN_TRAP_EN
    check32("mis_ram", if1.ReadData_Out, 32'hDEADBEEF);
`else
    check32("mis_ram", if1.ReadData_Out, 32'h77777777);
`endif
    check1("mis_fault_clr", if1.Fault_Out, 1'b0);

    // Latency 3 load @0x20
    sel(3);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h20, 32'hCAFEF00D, 5'd0);
    tick();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h20, 32'h0, 5'd7);
    #1 check1("l3_stall0", if3.Stall_Out, 1'b1);
    tick();
    check1("l3_bub1_valid", if3.Valid_Out, 1'b0);
    check1("l3_bub1_rw",    if3.RegWriteEN_Out, 1'b0);
    check1("l3_stall1",     if3.Stall_Out, 1'b1);
    tick();
    check1("l3_bub2_valid", if3.Valid_Out, 1'b0);
    check1("l3_stall2",     if3.Stall_Out, 1'b0);
    tick();
    set_idle();
    check1 ("l3_valid", if3.Valid_Out, 1'b1);
    check32("l3_data",  if3.ReadData_Out, 32'hCAFEF00D);
    check1 ("l3_rw",    if3.RegWriteEN_Out, 1'b1);
    check32("l3_wreg",  {27'd0, if3.WriteReg_Out}, 32'd7);
    #1 check1("l3_stall_idle", if3.Stall_Out, 1'b0);

    // Latency 4 load aborted by reset in its second busy cycle
    sel(4);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h30, 32'h0BADF00D, 5'd0);
    tick();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h30, 32'h0, 5'd9);
    #1 check1("l4_stall0", if4.Stall_Out, 1'b1);
    tick();
    check1("l4_stall1", if4.Stall_Out, 1'b1);
    tick();
    rst = 1'b1;
    #1 check1("l4_rst_stall", if4.Stall_Out, 1'b0);
    tick();
    rst = 1'b0;
    set_idle();
    check1 ("l4_rst_valid", if4.Valid_Out, 1'b0);
    check1 ("l4_rst_rw",    if4.RegWriteEN_Out, 1'b0);
    check32("l4_rst_rdata", if4.ReadData_Out, 32'h0);
    #1 check1("l4_rst_idle", if4.Stall_Out, 1'b0);

    // Full latency 4 load after reset: 3 stalls, data on the 4th edge
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h30, 32'h0, 5'd9);
    #1;
    for (int i = 0; i < 3; i++) begin
      check1($sformatf("l4_stall_%0d", i), if4.Stall_Out, 1'b1);
      tick();
      check1($sformatf("l4_bub_%0d", i), if4.Valid_Out, 1'b0);
    end
    check1("l4_stall_last", if4.Stall_Out, 1'b0);
    tick();
    set_idle();
    check1 ("l4_valid", if4.Valid_Out, 1'b1);
    check32("l4_data",  if4.ReadData_Out, 32'h0BADF00D);
    check32("l4_wreg",  {27'd0, if4.WriteReg_Out}, 32'd9);

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
